rvfi_dmem_responder: RTL and testbench
======================================

// Module: rvfi_dmem_responder
// PURPOSE
//  Behavioural data-memory responder for formal/sim harnesses: serves a core's valid/ready data bus
//  from a small byte-writable word array with configurable, stallable latency. Each completed access
//  is also emitted as an RVFI-style memory record (addr/rmask/wmask/rdata/wdata), the producer side
//  of the memory fields consumed by the dmem consistency checks. One outstanding request at a time.
// PARAMETERS
//  XLEN        32           data/address width; XLEN/8 byte lanes
//  DEPTH_LOG2  4            log2 of number of XLEN-bit words held
//  ADDR_BASE   32'h0        byte address of word 0; must be XLEN/8-aligned
//  LATENCY     2            unstalled cycles from acceptance to mem_ready (>=1, <=255)
// PORTS
//  clk          in   1        clock, all state on rising edge
//  resetn       in   1        asynchronous active-low reset
//  stall        in   1        1 = freeze latency counter this cycle (harness drives $anyseq/random)
//  mem_valid    in   1        request valid; held until mem_ready
//  mem_ready    out  1        one-cycle completion pulse
//  mem_addr     in   XLEN     byte address
//  mem_wstrb    in   XLEN/8   byte write strobes; 0 = read
//  mem_wdata    in   XLEN     write data
//  mem_rdata    out  XLEN     read data, valid with mem_ready
//  mem_err      out  1        with mem_ready: misaligned or out-of-window access
//  proto_err    out  1        sticky: mem_valid dropped mid-request
//  trace_valid  out  1        == mem_ready
//  trace_addr   out  XLEN     accepted mem_addr
//  trace_rmask  out  XLEN/8   all-ones for a legal read, else 0
//  trace_wmask  out  XLEN/8   accepted mem_wstrb for a legal write, else 0
//  trace_rdata  out  XLEN     == mem_rdata
//  trace_wdata  out  XLEN     accepted mem_wdata, lanes outside wmask forced 0
// BEHAVIOUR
//  Reset: state IDLE, counter 0, all outputs 0, proto_err 0, every array word 0.
//  FSM IDLE -> WAIT -> RESP -> IDLE.
//   IDLE: mem_valid=1 captures addr/wstrb/wdata, cnt<=LATENCY-1; go WAIT (RESP if LATENCY==1).
//   WAIT: stall=0 decrements cnt; at cnt==0 with stall=0 go RESP. stall=1 holds cnt.
//   RESP: mem_ready=1, trace_valid=1 for exactly this cycle; write commits at this edge; -> IDLE.
//  Latency: unstalled acceptance cycle T gives mem_ready at T+LATENCY; each stall cycle adds one.
//  No back-to-back acceptance: IDLE cycle required after RESP (min 2-cycle request spacing).
//  Decode: idx=(addr-ADDR_BASE)>>log2(XLEN/8), unsigned subtract (wrap below base -> out of window).
//   Legal iff addr low bits 0 and idx<2**DEPTH_LOG2. Illegal: mem_err=1, rdata=0, no write, masks 0.
//  Read: rdata = array[idx] sampled at RESP (reflects all earlier committed writes).
//  Write: only strobed lanes updated; mem_rdata for writes returns pre-write word; trace_rmask=0.
//  Captured request used throughout; mem_addr/wstrb/wdata changes after acceptance ignored.
//  mem_valid low in WAIT: proto_err<=1 (sticky until reset), abort to IDLE, no ready, no write.
//  Async reset mid-request: immediate return to IDLE, outputs 0, pending write dropped, array cleared.
//  mem_ready/mem_rdata/mem_err/trace_* registered; zero when not in RESP.
// TESTING
//  1 reset, LATENCY=2: write addr 0x8 wstrb 4'hF wdata 0xDEADBEEF at T -> ready at T+2, wmask F, err 0.
//  2 read 0x8 after 1 -> rdata 0xDEADBEEF, trace_rmask F; write 0x8 wstrb 4'h2 data 0x00001100 -> read 0xDEAD11EF.
//  3 read 0x6 (misaligned) and 0x40 (DEPTH_LOG2=4) -> ready, err=1, rdata 0, masks 0; array unchanged.
//  4 stall held 3 cycles in WAIT -> ready at T+5; counter resumes, single ready pulse.
//  5 drop mem_valid one cycle into WAIT -> proto_err=1 sticky, no ready, target word unchanged.
//  6 resetn low in WAIT of a write to 0x0 -> outputs 0 at once; after release read 0x0 returns 0.

Source files
------------

// File: rtl/rvfi_dmem_responder.sv
// rvfi_dmem_responder
// Behavioural data-memory responder. It serves a valid/ready data bus from a
// small byte-writable word array. The latency is configurable and can be
// stretched by stall cycles. Every completed access is also published as an
// RVFI-style memory record. Only one request is outstanding at a time.
module rvfi_dmem_responder #(
    parameter int              XLEN       = 32,
    parameter int              DEPTH_LOG2 = 4,
    parameter logic [XLEN-1:0] ADDR_BASE  = {XLEN{1'b0}},
    parameter int              LATENCY    = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              stall,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [XLEN-1:0]   mem_addr,
    input  logic [XLEN/8-1:0] mem_wstrb,
    input  logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN-1:0]   mem_rdata,
    output logic              mem_err,
    output logic              proto_err,
    output logic              trace_valid,
    output logic [XLEN-1:0]   trace_addr,
    output logic [XLEN/8-1:0] trace_rmask,
    output logic [XLEN/8-1:0] trace_wmask,
    output logic [XLEN-1:0]   trace_rdata,
    output logic [XLEN-1:0]   trace_wdata
);

    localparam int         NB       = XLEN / 8;
    localparam int         ALIGN    = $clog2(NB);
    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);
    localparam bit         LAT_ONE  = (LATENCY == 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Expand per-lane strobes into a per-bit mask.
    function automatic logic [XLEN-1:0] lane_mask(input logic [NB-1:0] m);
        logic [XLEN-1:0] r;
        r = {XLEN{1'b0}};
        for (int b = 0; b < NB; b++) begin
            r[8*b +: 8] = {8{m[b]}};
        end
        return r;
    endfunction

    state_t          state_r;
    logic [7:0]      cnt_r;
    logic [XLEN-1:0] req_addr_r;
    logic [NB-1:0]   req_wstrb_r;
    logic [XLEN-1:0] req_wdata_r;
    logic [XLEN-1:0] mem_r [DEPTH];

    logic            mem_ready_r;
    logic [XLEN-1:0] mem_rdata_r;
    logic            mem_err_r;
    logic            proto_err_r;
    logic [XLEN-1:0] trace_addr_r;
    logic [NB-1:0]   trace_rmask_r;
    logic [NB-1:0]   trace_wmask_r;
    logic [XLEN-1:0] trace_wdata_r;

    // A request that completes straight out of IDLE (LATENCY==1) has not yet been captured.
    logic [XLEN-1:0]       cur_addr_s;
    logic [NB-1:0]         cur_wstrb_s;
    logic [XLEN-1:0]       cur_wdata_s;
    logic [XLEN-1:0]       off_s;
    logic [DEPTH_LOG2-1:0] idx_s;
    logic                  legal_s;
    logic                  enter_resp_s;
    logic [NB-1:0]         wmask_s;

    // Select the request source, decode the window and detect entry into RESP.
    always_comb begin
        if (state_r == ST_IDLE) begin
            cur_addr_s  = mem_addr;
            cur_wstrb_s = mem_wstrb;
            cur_wdata_s = mem_wdata;
        end else begin
            cur_addr_s  = req_addr_r;
            cur_wstrb_s = req_wstrb_r;
            cur_wdata_s = req_wdata_r;
        end
        // Unsigned subtract: addresses below the base wrap far out of the window.
        off_s   = cur_addr_s - ADDR_BASE;
        idx_s   = off_s[ALIGN +: DEPTH_LOG2];
        legal_s = (off_s[ALIGN-1:0] == {ALIGN{1'b0}}) &&
                  (off_s[XLEN-1:ALIGN+DEPTH_LOG2] == {(XLEN-ALIGN-DEPTH_LOG2){1'b0}});
        if (legal_s) begin
            wmask_s = cur_wstrb_s;
        end else begin
            wmask_s = {NB{1'b0}};
        end
        case (state_r)
            ST_IDLE: enter_resp_s = mem_valid && LAT_ONE;
            ST_WAIT: enter_resp_s = mem_valid && !stall && (cnt_r == 8'd1);
            default: enter_resp_s = 1'b0;
        endcase
    end

    // Request FSM with the latency counter and registered response/trace outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r       <= ST_IDLE;
            cnt_r         <= 8'd0;
            req_addr_r    <= {XLEN{1'b0}};
            req_wstrb_r   <= {NB{1'b0}};
            req_wdata_r   <= {XLEN{1'b0}};
            mem_ready_r   <= 1'b0;
            mem_rdata_r   <= {XLEN{1'b0}};
            mem_err_r     <= 1'b0;
            proto_err_r   <= 1'b0;
            trace_addr_r  <= {XLEN{1'b0}};
            trace_rmask_r <= {NB{1'b0}};
            trace_wmask_r <= {NB{1'b0}};
            trace_wdata_r <= {XLEN{1'b0}};
        end else begin
            // Response outputs are zero except during the single RESP cycle.
            mem_ready_r   <= 1'b0;
            mem_rdata_r   <= {XLEN{1'b0}};
            mem_err_r     <= 1'b0;
            trace_addr_r  <= {XLEN{1'b0}};
            trace_rmask_r <= {NB{1'b0}};
            trace_wmask_r <= {NB{1'b0}};
            trace_wdata_r <= {XLEN{1'b0}};
            if (enter_resp_s) begin
                mem_ready_r   <= 1'b1;
                mem_err_r     <= !legal_s;
                // Writes return the word as it was before this write lands.
                mem_rdata_r   <= legal_s ? mem_r[idx_s] : {XLEN{1'b0}};
                trace_addr_r  <= cur_addr_s;
                trace_rmask_r <= (legal_s && (cur_wstrb_s == {NB{1'b0}})) ? {NB{1'b1}} : {NB{1'b0}};
                trace_wmask_r <= wmask_s;
                trace_wdata_r <= cur_wdata_s & lane_mask(wmask_s);
            end
            case (state_r)
                ST_IDLE: begin
                    if (mem_valid) begin
                        req_addr_r  <= mem_addr;
                        req_wstrb_r <= mem_wstrb;
                        req_wdata_r <= mem_wdata;
                        cnt_r       <= CNT_INIT;
                        state_r     <= LAT_ONE ? ST_RESP : ST_WAIT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (!mem_valid) begin
                        proto_err_r <= 1'b1;
                        cnt_r       <= 8'd0;
                        state_r     <= ST_IDLE;
                    end else if (stall) begin
                        state_r <= ST_WAIT;
                    end else begin
                        cnt_r   <= cnt_r - 8'd1;
                        state_r <= (cnt_r == 8'd1) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Word array: cleared on reset, strobed lanes of a legal write commit on entry to RESP.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {XLEN{1'b0}};
            end
        end else begin
            if (enter_resp_s && legal_s) begin
                for (int b = 0; b < NB; b++) begin
                    if (cur_wstrb_s[b]) begin
                        mem_r[idx_s][8*b +: 8] <= cur_wdata_s[8*b +: 8];
                    end else begin
                        mem_r[idx_s][8*b +: 8] <= mem_r[idx_s][8*b +: 8];
                    end
                end
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_r[i] <= mem_r[i];
                end
            end
        end
    end

    assign mem_ready   = mem_ready_r;
    assign mem_rdata   = mem_rdata_r;
    assign mem_err     = mem_err_r;
    assign proto_err   = proto_err_r;
    assign trace_valid = mem_ready_r;
    assign trace_addr  = trace_addr_r;
    assign trace_rmask = trace_rmask_r;
    assign trace_wmask = trace_wmask_r;
    assign trace_rdata = mem_rdata_r;
    assign trace_wdata = trace_wdata_r;

endmodule

// File: tb/tb_rvfi_dmem_responder.sv
// Scoreboard bench for rvfi_dmem_responder (XLEN=32, DEPTH_LOG2=4, LATENCY=2).
module tb_rvfi_dmem_responder;

    logic        clk;
    logic        resetn;
    logic        stall;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic        proto_err;
    logic        trace_valid;
    logic [31:0] trace_addr;
    logic [3:0]  trace_rmask;
    logic [3:0]  trace_wmask;
    logic [31:0] trace_rdata;
    logic [31:0] trace_wdata;

    rvfi_dmem_responder #(
        .XLEN(32), .DEPTH_LOG2(4), .ADDR_BASE(32'h0), .LATENCY(2)
    ) dut (
        .clk(clk), .resetn(resetn), .stall(stall),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_err(mem_err), .proto_err(proto_err), .trace_valid(trace_valid),
        .trace_addr(trace_addr), .trace_rmask(trace_rmask), .trace_wmask(trace_wmask),
        .trace_rdata(trace_rdata), .trace_wdata(trace_wdata)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [31:0] wdata;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic        err;
    } rec_t;

    rec_t        exp_q[$];
    logic [31:0] model [16];
    int          tests_run = 0;
    int          tests_failed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare each completed access against the oldest expected record.
    always @(negedge clk) begin
        if (resetn && mem_ready) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_ready", 32'd1, 32'd0);
            end else begin
                rec_t r;
                r = exp_q.pop_front();
                check_val("rdata", mem_rdata, r.rdata);
                check_val("err", {31'd0, mem_err}, {31'd0, r.err});
                check_val("trace_valid", {31'd0, trace_valid}, 32'd1);
                check_val("trace_addr", trace_addr, r.addr);
                check_val("trace_rmask", {28'd0, trace_rmask}, {28'd0, r.rmask});
                check_val("trace_wmask", {28'd0, trace_wmask}, {28'd0, r.wmask});
                check_val("trace_rdata", trace_rdata, r.rdata);
                check_val("trace_wdata", trace_wdata, r.wdata);
            end
        end
    end

    // Issue one request, predict its record, and check latency and pulse width.
    task automatic do_req(input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d, input int stalls);
        rec_t        r;
        logic        ok;
        logic [3:0]  idx;
        logic [31:0] bm;
        int          n;
        ok  = (a[1:0] == 2'b00) && (a < 32'h40);
        idx = a[5:2];
        r.addr  = a;
        r.err   = !ok;
        r.rdata = ok ? model[idx] : 32'h0;
        r.rmask = (ok && s == 4'h0) ? 4'hF : 4'h0;
        r.wmask = ok ? s : 4'h0;
        bm = {{8{r.wmask[3]}}, {8{r.wmask[2]}}, {8{r.wmask[1]}}, {8{r.wmask[0]}}};
        r.wdata = d & bm;
        exp_q.push_back(r);
        if (ok) model[idx] = (model[idx] & ~bm) | (d & bm);
        mem_addr  = a;
        mem_wstrb = s;
        mem_wdata = d;
        mem_valid = 1'b1;
        n = 0;
        while (n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (mem_ready) break;
            if (n == 1) begin
                // Request is captured; later bus changes must have no effect.
                mem_addr  = $urandom;
                mem_wstrb = 4'($urandom);
                mem_wdata = $urandom;
                if (stalls > 0) stall = 1'b1;
            end
            if (n == 1 + stalls) stall = 1'b0;
        end
        check_val("latency", n, 2 + stalls);
        mem_valid = 1'b0;
        stall = 1'b0;
        @(posedge clk);
        #1;
        check_val("ready_pulse", {31'd0, mem_ready}, 32'd0);
        check_val("idle_rdata", mem_rdata, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        resetn = 1'b0; stall = 1'b0; mem_valid = 1'b0;
        mem_addr = 32'h0; mem_wstrb = 4'h0; mem_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        check_val("reset_ready", {31'd0, mem_ready}, 32'd0);
        check_val("reset_proto", {31'd0, proto_err}, 32'd0);
        check_val("reset_rdata", mem_rdata, 32'd0);
        @(posedge clk);
        #1;

        // Full write, read back, partial write, read back.
        do_req(32'h8, 4'hF, 32'hDEADBEEF, 0);
        do_req(32'h8, 4'h0, 32'h0, 0);
        do_req(32'h8, 4'h2, 32'h00001100, 0);
        do_req(32'h8, 4'h0, 32'h0, 0);
        // Illegal accesses: misaligned, above the window, misaligned write.
        do_req(32'h6, 4'h0, 32'h0, 0);
        do_req(32'h40, 4'h0, 32'h0, 0);
        do_req(32'h6, 4'hF, 32'hFFFFFFFF, 0);
        do_req(32'h4, 4'h0, 32'h0, 0);
        do_req(32'h8, 4'h0, 32'h0, 0);
        // Stalls stretch the latency one cycle each.
        do_req(32'h4, 4'hF, 32'hCAFEF00D, 3);
        do_req(32'h4, 4'h0, 32'h0, 1);
        do_req(32'h3C, 4'h9, 32'h11223344, 2);
        do_req(32'h3C, 4'h0, 32'h0, 0);

        // Drop mem_valid mid-request.
        mem_addr = 32'h10; mem_wstrb = 4'hF; mem_wdata = 32'hA5A5A5A5; mem_valid = 1'b1;
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        @(posedge clk);
        #1;
        check_val("proto_err_set", {31'd0, proto_err}, 32'd1);
        repeat (4) begin
            @(posedge clk);
            #1;
            check_val("abort_no_ready", {31'd0, mem_ready}, 32'd0);
        end
        do_req(32'h10, 4'h0, 32'h0, 0);
        check_val("proto_err_sticky", {31'd0, proto_err}, 32'd1);

        // Reset in the middle of a write.
        do_req(32'h0, 4'hF, 32'h12345678, 0);
        do_req(32'h0, 4'h0, 32'h0, 0);
        mem_addr = 32'h0; mem_wstrb = 4'hF; mem_wdata = 32'hFFFFFFFF; mem_valid = 1'b1;
        @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        check_val("rst_ready", {31'd0, mem_ready}, 32'd0);
        check_val("rst_proto", {31'd0, proto_err}, 32'd0);
        check_val("rst_rdata", mem_rdata, 32'd0);
        check_val("rst_wmask", {28'd0, trace_wmask}, 32'd0);
        mem_valid = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        do_req(32'h0, 4'h0, 32'h0, 0);
        do_req(32'h8, 4'h0, 32'h0, 0);

        repeat (3) @(posedge clk);
        check_val("queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
